// File: rtl/gol_sched_pkg.sv
// Shared types and default sizes for the Game-of-Life bank scheduler.
package gol_sched_pkg;

   localparam int SCHED_ROWS   = 720;
   localparam int SCHED_LINE_W = 1280;
   localparam int SCHED_ROW_AW = 10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_CALC = 3'd2,
      ST_SWAP = 3'd3
   } sched_state_t;

   typedef enum logic [2:0] {
      RQ_NONE   = 3'd0,
      RQ_DISP   = 3'd1,
      RQ_INIT   = 3'd2,
      RQ_CALC_R = 3'd3,
      RQ_CALC_W = 3'd4
   } req_id_t;

endpackage

// File: rtl/bank_port_mux.sv
// Single-port BRAM access mux; the current-role bank serves display, row load
// and engine reads, the next-role bank serves only engine writes.
module bank_port_mux
   import gol_sched_pkg::*;
#(
   parameter int ROW_AW = SCHED_ROW_AW,
   parameter int LINE_W = SCHED_LINE_W
) (
   input  logic              is_cur,
   input  logic              disp_req,
   input  logic [ROW_AW-1:0] disp_row,
   input  logic              init_wr,
   input  logic [ROW_AW-1:0] init_row,
   input  logic [LINE_W-1:0] init_line,
   input  logic              calc_rreq,
   input  logic [ROW_AW-1:0] calc_rrow,
   input  logic              calc_wreq,
   input  logic [ROW_AW-1:0] calc_wrow,
   input  logic [LINE_W-1:0] calc_wline,
   output logic [ROW_AW-1:0] addr,
   output logic [LINE_W-1:0] din,
   output logic              we,
   output req_id_t           gnt_id
);

   always_comb begin
      addr   = '0;
      din    = '0;
      we     = 1'b0;
      gnt_id = RQ_NONE;
      if (is_cur) begin
         // the display never stalls, so it outranks both loader and engine
         if (disp_req) begin
            addr   = disp_row;
            gnt_id = RQ_DISP;
         end else if (init_wr) begin
            addr   = init_row;
            din    = init_line;
            we     = 1'b1;
            gnt_id = RQ_INIT;
         end else if (calc_rreq) begin
            addr   = calc_rrow;
            gnt_id = RQ_CALC_R;
         end
      end else if (calc_wreq) begin
         addr   = calc_wrow;
         din    = calc_wline;
         we     = 1'b1;
         gnt_id = RQ_CALC_W;
      end
   end

endmodule

// File: rtl/gol_bank_scheduler.sv
// Ping-pong bank sequencer and port arbiter for the Game-of-Life line BRAMs.
// GOL_TEARFREE_SWAP_EN: hold the bank swap until the display's frame_done.
//
// state | meaning
// IDLE  | waiting; init_en starts a row load, else !pause starts a generation
// LOAD  | writing init rows 0..ROWS-1 into the current bank
// CALC  | engine reads current bank, writes next bank
// SWAP  | generation complete, waiting to flip cur_bank
module gol_bank_scheduler
   import gol_sched_pkg::*;
#(
   parameter int ROWS   = SCHED_ROWS,
   parameter int LINE_W = SCHED_LINE_W,
   parameter int ROW_AW = SCHED_ROW_AW,
   parameter int RD_LAT = 1
) (
   input  logic              out_stream_aclk,
   input  logic              periph_resetn,
   input  logic              pause,
   input  logic              init_en,
   input  logic              init_valid,
   output logic              init_ready,
   input  logic [LINE_W-1:0] init_line,
   output logic              load_done,
   input  logic              disp_req,
   input  logic [ROW_AW-1:0] disp_row,
   output logic              disp_rvalid,
   output logic [LINE_W-1:0] disp_line,
   input  logic              frame_done,
   output logic              calc_start,
   input  logic              calc_done,
   input  logic              calc_rreq,
   input  logic [ROW_AW-1:0] calc_rrow,
   output logic              calc_rgnt,
   output logic              calc_rvalid,
   output logic [LINE_W-1:0] calc_rline,
   input  logic              calc_wreq,
   input  logic [ROW_AW-1:0] calc_wrow,
   input  logic [LINE_W-1:0] calc_wline,
   output logic              calc_wgnt,
   output logic [ROW_AW-1:0] bank_a_addr,
   output logic [LINE_W-1:0] bank_a_din,
   output logic              bank_a_we,
   input  logic [LINE_W-1:0] bank_a_dout,
   output logic [ROW_AW-1:0] bank_b_addr,
   output logic [LINE_W-1:0] bank_b_din,
   output logic              bank_b_we,
   input  logic [LINE_W-1:0] bank_b_dout,
   output logic              cur_bank,
   output logic [31:0]       gen_count,
   output logic [2:0]        sched_state
);

   sched_state_t      state;
   logic [ROW_AW-1:0] row_cnt;
   logic              init_wr;
   logic              calc_rd;
   logic              calc_wr;
   logic              swap_go;
   req_id_t           gnt_a;
   req_id_t           gnt_b;
   logic [RD_LAT-1:0] disp_pipe;
   logic [RD_LAT-1:0] calc_pipe;
   logic [RD_LAT-1:0] bank_pipe;
   logic [LINE_W-1:0] ret_line;

`ifdef GOL_TEARFREE_SWAP_EN
   assign swap_go = frame_done;
`else
   logic unused_frame_done;
   assign unused_frame_done = frame_done;
   assign swap_go = 1'b1;
`endif

   assign init_ready = (state == ST_LOAD) && init_en && !disp_req;
   assign init_wr    = init_valid && init_ready;
   assign calc_rd    = (state == ST_CALC) && calc_rreq;
   assign calc_wr    = (state == ST_CALC) && calc_wreq;

   bank_port_mux #(.ROW_AW(ROW_AW), .LINE_W(LINE_W)) u_mux_a (
      .is_cur(!cur_bank), .disp_req(disp_req), .disp_row(disp_row),
      .init_wr(init_wr), .init_row(row_cnt), .init_line(init_line),
      .calc_rreq(calc_rd), .calc_rrow(calc_rrow),
      .calc_wreq(calc_wr), .calc_wrow(calc_wrow), .calc_wline(calc_wline),
      .addr(bank_a_addr), .din(bank_a_din), .we(bank_a_we), .gnt_id(gnt_a)
   );

   bank_port_mux #(.ROW_AW(ROW_AW), .LINE_W(LINE_W)) u_mux_b (
      .is_cur(cur_bank), .disp_req(disp_req), .disp_row(disp_row),
      .init_wr(init_wr), .init_row(row_cnt), .init_line(init_line),
      .calc_rreq(calc_rd), .calc_rrow(calc_rrow),
      .calc_wreq(calc_wr), .calc_wrow(calc_wrow), .calc_wline(calc_wline),
      .addr(bank_b_addr), .din(bank_b_din), .we(bank_b_we), .gnt_id(gnt_b)
   );

   assign calc_rgnt = (cur_bank ? gnt_b : gnt_a) == RQ_CALC_R;
   assign calc_wgnt = (cur_bank ? gnt_a : gnt_b) == RQ_CALC_W;

   // bank identity travels with the read so a swap mid-flight cannot redirect it
   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
         disp_pipe <= '0;
         calc_pipe <= '0;
         bank_pipe <= '0;
      end else begin
         disp_pipe[0] <= disp_req;
         calc_pipe[0] <= calc_rgnt;
         bank_pipe[0] <= cur_bank;
         for (int i = 1; i < RD_LAT; i++) begin
            disp_pipe[i] <= disp_pipe[i-1];
            calc_pipe[i] <= calc_pipe[i-1];
            bank_pipe[i] <= bank_pipe[i-1];
         end
      end
   end

   assign ret_line    = bank_pipe[RD_LAT-1] ? bank_b_dout : bank_a_dout;
   assign disp_rvalid = disp_pipe[RD_LAT-1];
   assign calc_rvalid = calc_pipe[RD_LAT-1];
   assign disp_line   = ret_line;
   assign calc_rline  = ret_line;
   assign sched_state = state;

   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
         state      <= ST_IDLE;
         row_cnt    <= '0;
         cur_bank   <= 1'b0;
         gen_count  <= '0;
         calc_start <= 1'b0;
         load_done  <= 1'b0;
      end else begin
         calc_start <= 1'b0;
         load_done  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (init_en) begin
                  state <= ST_LOAD;
               end else if (!pause) begin
                  calc_start <= 1'b1;
                  state      <= ST_CALC;
               end
            end
            ST_LOAD: begin
               if (!init_en) begin
                  row_cnt <= '0;
                  state   <= ST_IDLE;
               end else if (init_wr) begin
                  if (row_cnt == ROW_AW'(ROWS - 1)) begin
                     row_cnt   <= '0;
                     load_done <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     row_cnt <= row_cnt + ROW_AW'(1);
                  end
               end
            end
            ST_CALC: begin
               if (calc_done) state <= ST_SWAP;
            end
            ST_SWAP: begin
               if (swap_go) begin
                  cur_bank  <= ~cur_bank;
                  gen_count <= gen_count + 32'd1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/gol_bank_scheduler.md
# gol_bank_scheduler

Sequencer and port arbiter for the two single-port 720×1280-bit line BRAMs that hold Game-of-Life generations. It owns the ping-pong bank selection: one bank is *current* (displayed and read by the compute engine), the other is *next* (written by the compute engine). It arbitrates single-port access between three requesters: display reader, regfile row loader and next-state engine. Banks are swapped only at a frame boundary, so the pixel stream never shows a half-computed generation.

## Interface
Parameters:
- ROWS, 720, rows per generation
- LINE_W, 1280, bits per row
- ROW_AW, 10, row address width
- RD_LAT, 1, BRAM read latency in cycles

Ports:
- out_stream_aclk  in  1  sole clock
- periph_resetn  in  1  asynchronous, active-low reset
- pause  in  1  level; blocks the start of a new generation
- init_en  in  1  level; requests load mode
- init_valid / init_ready  in / out  1 / 1  row-load handshake
- init_line  in  LINE_W  row data to load
- load_done  out  1  one-cycle pulse after row ROWS-1 is written
- disp_req / disp_row  in  1 / ROW_AW  display row read request
- disp_rvalid / disp_line  out  1 / LINE_W  display read return
- frame_done  in  1  pulse on the last pixel of a frame
- calc_start  out  1  one-cycle pulse that starts a generation
- calc_done  in  1  pulse when the engine has written all rows
- calc_rreq / calc_rrow / calc_rgnt  in / in / out  1 / ROW_AW / 1  engine read port
- calc_rvalid / calc_rline  out  1 / LINE_W  engine read return
- calc_wreq / calc_wrow / calc_wline / calc_wgnt  in / in / in / out  1 / ROW_AW / LINE_W / 1  engine write port
- bank_{a,b}_addr / _din / _we / _dout  out / out / out / in  ROW_AW / LINE_W / 1 / LINE_W  BRAM ports
- cur_bank  out  1  0 means A is current
- gen_count  out  32  completed generations
- sched_state  out  3  FSM state, for debug and regfile readback

## Operation
- FSM states: IDLE, LOAD, CALC, SWAP.
- IDLE:
  - if init_en → LOAD;
  - else if !pause → pulse calc_start, go to CALC.
  - init_en takes priority over a generation start.
- LOAD: rows are written into the current bank at a row counter 0..ROWS-1.
  - init_ready = init_en && !disp_req.
  - Each init_valid&&init_ready writes one row and increments the counter.
  - After row ROWS-1 is written: pulse load_done, clear the counter, go to IDLE.
  - init_en low during LOAD aborts the load: counter cleared, go to IDLE, no load_done pulse.
- CALC:
  - Current-bank priority: disp > calc read. calc_rgnt = calc_rreq && !disp_req.
  - Next bank: calc_wgnt = calc_wreq, with bank_we of the next bank = calc_wgnt.
  - On calc_done → SWAP. A calc_done and a frame_done in the same cycle do not swap; the swap waits for the next frame_done.
- SWAP:
  - On frame_done: toggle cur_bank, increment gen_count, go to IDLE.
  - The display keeps reading the old current bank until that frame_done.
- Display reads are always granted, in every state, on the current bank.
- Outside their owning state, engine grants and init_ready are 0.
- init_en, pause and engine requests are ignored in SWAP.
- gen_count wraps modulo 2^32.

## Timing
- Grants and bank_addr/_din/_we are combinational from requests and registered state. Everything else is registered.
- Read return: rvalid is asserted exactly RD_LAT cycles after a granted read, with the line from the bank granted at request time (the bank identity is tracked in a shift pipe).
  - A swap inside that window does not redirect the return.
- Reset values:
  - state IDLE;
  - cur_bank 0, gen_count 0, row counter 0;
  - calc_start, load_done, all rvalid, init_ready, grants, bank_we: 0.
- Reset mid-operation: all in-flight reads are discarded and no rvalid is emitted.
- calc_start is asserted in the single cycle the FSM leaves IDLE for CALC.

## Configuration
- GOL_TEARFREE_SWAP_EN defined: behaviour as above, with the swap gated by frame_done.
- GOL_TEARFREE_SWAP_EN undefined:
  - SWAP lasts exactly one cycle: cur_bank toggles unconditionally, then the FSM goes to IDLE.
  - frame_done is ignored.

## Structure
- Package gol_sched_pkg holds:
  - the state enum (IDLE/LOAD/CALC/SWAP);
  - the requester ID enum (NONE/DISP/INIT/CALC_R/CALC_W);
  - default constants ROWS, LINE_W, ROW_AW.
- Sub-module bank_port_mux, instantiated twice (A, B):
  - inputs: per-requester req/addr/data and the current/next role;
  - outputs: BRAM addr/din/we and the granted requester ID.
- The top level holds the FSM, row counter, gen_count and read-return pipe.

## Test plan
- Reset, pause=0 → calc_start pulse 1 cycle after reset release; sched_state=CALC; cur_bank=0.
- LOAD: init_en=1, 720 rows with init_valid continuous, disp_req idle → bank_a_we for addr 0..719 on consecutive cycles, load_done at the last write, FSM back to IDLE.
- Conflict: disp_req and calc_rreq in the same cycle in CALC, rows 5 and 9 → bank addr=5, calc_rgnt=0; next cycle calc granted; disp_rvalid then calc_rvalid, each RD_LAT after its grant.
- Tear-free swap: calc_done at cycle 100, frame_done at 400 → cur_bank toggles at 401, gen_count=1. With the macro undefined → toggle at 102.
- pause=1 held through SWAP → FSM stays in IDLE, no calc_start. Release → calc_start next cycle.
- Assert periph_resetn low during LOAD at row 300 with a read in flight → no rvalid. After release: counter 0, state IDLE.
